// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and address helpers for the cache block-fill controller.
// The same geometry (offset/index/tag split) is used by the cache and its arrays.
package cache_fill_fsm_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int BLK_WORDS  = 8;
  localparam int CNT_W      = 4;
  localparam int OFFSET_MSB = 3;
  localparam int INDEX_MSB  = 9;
  localparam int TAG_LSB    = 10;

  localparam logic [ADDR_W-1:0]     BLK_MASK  = 16'hFFF0;
  localparam logic [ADDR_W-1:0]     VALID_BIT = 16'h0001;
  localparam logic [OFFSET_MSB-1:0] LAST_IDX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TAG  = 2'd2
  } fill_state_e;

  // Byte offset of word idx inside the block; base low bits are zero so adding never carries.
  function automatic logic [ADDR_W-1:0] word_offset(input logic [OFFSET_MSB-1:0] idx);
    return {{(ADDR_W-OFFSET_MSB-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// Saturating 4-bit word counter used for the request and return sides of a block fill.
// done rises once all words of the block have been counted and the count then holds.
module fill_word_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  output logic [OFFSET_MSB-1:0] idx,
  output logic                  done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !count[CNT_W-1]) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign idx  = count[OFFSET_MSB-1:0];
  assign done = count[CNT_W-1];

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss fill controller: fetches an 8-word block from pipelined memory, streams it into the
// cache data array, then performs one tag/valid/LRU write. Stalls the pipeline throughout.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_wr_addr,
  output logic [DATA_W-1:0] cache_wr_data
);

  fill_state_e           state;
  fill_state_e           next_state;
  logic [ADDR_W-1:0]     base;
  logic [OFFSET_MSB-1:0] req_idx;
  logic [OFFSET_MSB-1:0] ret_idx;
  logic                  req_done;
  logic                  ret_done;
  logic                  in_fill;
  logic                  req_fire;
  logic                  ret_fire;

  assign in_fill  = (state == ST_FILL);
  assign req_fire = in_fill && !req_done;
  assign ret_fire = in_fill && memory_data_valid && !ret_done;

  fill_word_counter u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_fill),
    .en    (req_fire),
    .idx   (req_idx),
    .done  (req_done)
  );

  fill_word_counter u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_fill),
    .en    (ret_fire),
    .idx   (ret_idx),
    .done  (ret_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Block base is captured only when a fill is accepted, so later misses cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else if ((state == ST_IDLE) && miss_detected) begin
      base <= miss_address & BLK_MASK;
    end else begin
      base <= base;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = miss_detected ? ST_FILL : ST_IDLE;
      ST_FILL: next_state = (ret_fire && (ret_idx == LAST_IDX)) ? ST_TAG : ST_FILL;
      ST_TAG:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_wr_addr    = '0;
    cache_wr_data    = '0;
    case (state)
      ST_IDLE: begin
        // Stall the missing access in the same cycle it is detected.
        fsm_busy = miss_detected && !rst;
      end
      ST_FILL: begin
        fsm_busy         = 1'b1;
        mem_en           = req_fire;
        memory_address   = req_fire ? (base + word_offset(req_idx)) : '0;
        write_data_array = ret_fire;
        cache_wr_addr    = ret_fire ? (base + word_offset(ret_idx)) : base;
        cache_wr_data    = ret_fire ? memory_data : '0;
      end
      ST_TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        cache_wr_addr   = base + VALID_BIT;
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

endmodule
